// File: rtl/adder2.sv
// 4-bit carry-lookahead adder slice. Exposes the propagate vector so callers can
// recover the carry into any bit as p ^ s.
module adder2 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] s_o,
    output logic [3:0] p_o,
    output logic       cout_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate terms and flattened lookahead carries
    always_comb begin
        g    = a_i & b_i;
        p    = a_i ^ b_i;
        c[0] = cin_i;
        c[1] = g[0] | (p[0] & cin_i);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin_i);
        s_o    = p ^ c[3:0];
        p_o    = p;
        cout_o = c[4];
    end

endmodule

// File: rtl/nibble_serial_accumulator.sv
// Serial multi-word adder: adds WIDTH-bit operands one nibble per cycle, LSB first,
// through a single 4-bit CLA slice with the carry chained through a flop.
module nibble_serial_accumulator #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("nibble_serial_accumulator: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e                    state_q, state_d;
    logic   [IdxW-1:0]         idx_q, idx_d;
    logic                      carry_q, carry_d;
    logic   [NIB-1:0][3:0]     a_q, b_q;
    logic   [NIB-1:0][3:0]     sum_q, sum_d;
    logic                      cout_q, cout_d;
    logic                      ovf_q, ovf_d;
    logic                      load_ops;

    logic   [3:0]              nib_s;
    logic   [3:0]              nib_p;
    logic                      nib_c;

    adder2 u_adder2 (
        .a_i    (a_q[idx_q]),
        .b_i    (b_q[idx_q]),
        .cin_i  (carry_q),
        .s_o    (nib_s),
        .p_o    (nib_p),
        .cout_o (nib_c)
    );

    // Next-state: accept in idle, one nibble per cycle in add, hold result in done
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        load_ops = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    load_ops = 1'b1;
                    carry_d  = cin_i;
                    idx_d    = '0;
                    state_d  = StAdd;
                end
            end
            StAdd: begin
                sum_d[idx_q] = nib_s;
                carry_d      = nib_c;
                idx_d        = idx_q + IdxW'(1);
                if (idx_q == LastIdx) begin
                    cout_d  = nib_c;
                    // Carry into the MSB is p[3] ^ s[3] of the top nibble
                    ovf_d   = nib_p[3] ^ nib_s[3] ^ nib_c;
                    idx_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and result state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand capture on the input handshake only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (load_ops) begin
            a_q <= a_i;
            b_q <= b_i;
        end
    end

    // Handshake flags decode straight from the registered state
    always_comb begin
        in_ready_o  = (state_q == StIdle);
        out_valid_o = (state_q == StDone);
        sum_o       = sum_q;
        cout_o      = cout_q;
        ovf_o       = ovf_q;
    end

endmodule

// File: tb/tb_nibble_serial_accumulator.sv
// Bench for nibble_serial_accumulator: WIDTH=16 and WIDTH=4 instances, directed
// cases plus random traffic against an arithmetic reference model.
module tb_nibble_serial_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic        sel4;
    logic [15:0] a, b;

    logic        ir16, ov16, c16, o16;
    logic [15:0] s16;
    logic        ir4, ov4, c4, o4;
    logic [3:0]  s4;

    logic        obs_ready, obs_valid, obs_cout, obs_ovf;
    logic [15:0] obs_sum;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_accumulator #(.WIDTH(16)) u_dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid & ~sel4),
        .in_ready_o  (ir16),
        .a_i         (a),
        .b_i         (b),
        .cin_i       (cin),
        .out_valid_o (ov16),
        .out_ready_i (out_ready),
        .sum_o       (s16),
        .cout_o      (c16),
        .ovf_o       (o16)
    );

    nibble_serial_accumulator #(.WIDTH(4)) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid & sel4),
        .in_ready_o  (ir4),
        .a_i         (a[3:0]),
        .b_i         (b[3:0]),
        .cin_i       (cin),
        .out_valid_o (ov4),
        .out_ready_i (out_ready),
        .sum_o       (s4),
        .cout_o      (c4),
        .ovf_o       (o4)
    );

    // View of whichever instance is under test
    always_comb begin
        obs_ready = sel4 ? ir4 : ir16;
        obs_valid = sel4 ? ov4 : ov16;
        obs_sum   = sel4 ? {12'h000, s4} : s16;
        obs_cout  = sel4 ? c4 : c16;
        obs_ovf   = sel4 ? o4 : o16;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer addition over w bits, sign rule for overflow
    function automatic void model(input int w, input logic [15:0] x, input logic [15:0] y,
                                  input logic ci, output logic [15:0] s, output logic co,
                                  output logic ov);
        int unsigned mask, full, sx, sy, ss;
        mask = (32'd1 << w) - 1;
        full = (x & mask) + (y & mask) + ci;
        s    = 16'(full & mask);
        co   = full[w];
        sx   = (x >> (w - 1)) & 1;
        sy   = (y >> (w - 1)) & 1;
        ss   = (full >> (w - 1)) & 1;
        ov   = (sx == sy) && (ss != sx);
    endfunction

    task automatic run_txn(input logic [15:0] x, input logic [15:0] y, input logic ci,
                           input int stall, input string tag);
        int w, nib, n, lat;
        logic [15:0] es;
        logic ec, eo;
        w   = sel4 ? 4 : 16;
        nib = w / 4;
        model(w, x, y, ci, es, ec, eo);
        n = 0;
        while (!obs_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_idle"}, obs_ready, 1);
        if (!obs_ready) return;
        a = x; b = y; cin = ci; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble operands: they must not be sampled after the accept
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        lat = 0;
        while (!obs_valid && lat < nib + 3) begin
            check({tag, "_busy"}, obs_ready, 0);
            @(posedge clk); #1; lat++;
        end
        check({tag, "_lat"}, lat, nib);
        if (!obs_valid) return;
        check({tag, "_sum"}, obs_sum, es);
        check({tag, "_cout"}, obs_cout, ec);
        check({tag, "_ovf"}, obs_ovf, eo);
        check({tag, "_rdy_done"}, obs_ready, 0);
        repeat (stall) begin
            @(posedge clk); #1;
            check({tag, "_hold_v"}, obs_valid, 1);
            check({tag, "_hold_s"}, {obs_ovf, obs_cout, obs_sum}, {eo, ec, es});
            check({tag, "_hold_r"}, obs_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_rel_v"}, obs_valid, 0);
        check({tag, "_rel_r"}, obs_ready, 1);
        check({tag, "_kept"}, {obs_ovf, obs_cout, obs_sum}, {eo, ec, es});
    endtask

    initial begin
        logic [15:0] bx [5];
        logic [15:0] by [5];
        logic [15:0] es;
        logic ec, eo;
        int n, lat, acc, last;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sel4 = 1'b0;
        #12;
        check("rst_ready16", ir16, 1);
        check("rst_ready4", ir4, 1);
        check("rst_out16", {ov16, c16, o16, s16}, 0);
        check("rst_out4", {ov4, c4, o4, s4}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(16'hFFFF, 16'h0001, 1'b0, 0, "ripple");
        run_txn(16'h7FFF, 16'h0001, 1'b0, 0, "posovf");
        run_txn(16'h8000, 16'h8000, 1'b0, 0, "negovf");
        run_txn(16'h1234, 16'h4321, 1'b1, 5, "bp");
        run_txn(16'h0000, 16'h0000, 1'b1, 0, "after_bp");

        // Back-to-back: in_valid held, new operands queued before each accept
        bx = '{16'h0001, 16'hABCD, 16'h7FFF, 16'h1111, 16'hFFFF};
        by = '{16'h0002, 16'h5432, 16'h7FFF, 16'hEEEF, 16'hFFFF};
        out_ready = 1'b1; in_valid = 1'b1; last = 0;
        for (int k = 0; k < 5; k++) begin
            a = bx[k]; b = by[k]; cin = 1'b0;
            n = 0;
            while (!obs_ready && n < 20) begin
                @(posedge clk); #1; n++;
            end
            @(posedge clk); #1;
            acc = cyc;
            if (k == 4) in_valid = 1'b0;
            if (k > 0) check("b2b_gap", acc - last, 6);
            last = acc;
            lat = 0;
            while (!obs_valid && lat < 8) begin
                @(posedge clk); #1; lat++;
            end
            model(16, bx[k], by[k], 1'b0, es, ec, eo);
            check("b2b_lat", lat, 4);
            check("b2b_res", {obs_ovf, obs_cout, obs_sum}, {eo, ec, es});
        end
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Asynchronous reset two edges into the add phase
        a = 16'h0F0F; b = 16'hF0F0; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", obs_valid, 0);
        check("mid_rst_ready", obs_ready, 1);
        check("mid_rst_out", {obs_ovf, obs_cout, obs_sum}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", obs_valid, 0);
        run_txn(16'h00FF, 16'h0F01, 1'b0, 0, "post_rst");

        for (int i = 0; i < 1000; i++) begin
            run_txn(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                    "rnd16");
        end
        sel4 = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 1000; i++) begin
            run_txn(16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)), 1'($urandom),
                    int'($urandom_range(0, 3)), "rnd4");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
